// File: rtl/rob_param.sv
// Parameterised reorder buffer: in-order allocate at the tail, out-of-order
// completion via the common data bus, and in-order retirement from the head.
module rob_param #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 16,
  parameter  int REG_W  = 4,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  ready_r;
  logic [REG_W-1:0]  dest_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [TAG_W-1:0]  head_r;
  logic [TAG_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic full_s;
  logic alloc_fire_s;
  logic commit_fire_s;

  // Handshake decode; alloc_ready deliberately uses pre-commit occupancy.
  always_comb begin
    full_s        = (count_r == CNT_W'(DEPTH));
    alloc_fire_s  = alloc_valid && !full_s;
    commit_fire_s = valid_r[head_r] && ready_r[head_r] && !flush;
  end

  assign alloc_ready  = !full_s;
  assign alloc_tag    = tail_r;
  assign full         = full_s;
  assign empty        = (count_r == {CNT_W{1'b0}});
  assign count        = count_r;
  assign rd_ready     = valid_r[rd_tag] && ready_r[rd_tag];
  assign rd_data      = data_r[rd_tag];
  assign commit_valid = commit_fire_s;
  assign commit_dest  = dest_r[head_r];
  assign commit_data  = data_r[head_r];
  assign commit_tag   = head_r;

  // Entry array and pointer update; flush overrides every other action.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      ready_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i] <= {REG_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
      end
      head_r  <= {TAG_W{1'b0}};
      tail_r  <= {TAG_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      valid_r <= {DEPTH{1'b0}};
      ready_r <= {DEPTH{1'b0}};
      head_r  <= {TAG_W{1'b0}};
      tail_r  <= {TAG_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Allocate wins over a CDB write that targets the same slot.
        if (alloc_fire_s && (tail_r == TAG_W'(i))) begin
          valid_r[i] <= 1'b1;
          ready_r[i] <= 1'b0;
          dest_r[i]  <= alloc_dest;
          data_r[i]  <= {DATA_W{1'b0}};
        end else begin
          if (cdb_valid && (cdb_tag == TAG_W'(i)) && valid_r[i]) begin
            ready_r[i] <= 1'b1;
            data_r[i]  <= cdb_data;
          end else begin
            ready_r[i] <= ready_r[i];
            data_r[i]  <= data_r[i];
          end
          if (commit_fire_s && (head_r == TAG_W'(i))) begin
            valid_r[i] <= 1'b0;
          end else begin
            valid_r[i] <= valid_r[i];
          end
        end
      end
      if (alloc_fire_s) begin
        tail_r <= tail_r + TAG_W'(1);
      end else begin
        tail_r <= tail_r;
      end
      if (commit_fire_s) begin
        head_r <= head_r + TAG_W'(1);
      end else begin
        head_r <= head_r;
      end
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param at default parameters (DEPTH=8, DATA_W=16, REG_W=4).
module tb_rob_param;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [3:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  rd_tag;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        flush;
  logic        commit_valid;
  logic [3:0]  commit_dest;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  rob_param dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush),
    .commit_valid(commit_valid), .commit_dest(commit_dest),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 2 time units after it.
  task automatic tick();
    @(posedge clk1);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_dest = 4'd0;
    cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'd0;
    rd_tag = 3'd0; flush = 1'b0;
    #12;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    tick();

    // Allocate dests 3,5,7 -> tags 0,1,2
    alloc_valid = 1'b1; alloc_dest = 4'd3; #1;
    check("alloc0_tag", 32'(alloc_tag), 32'd0);
    tick();
    alloc_dest = 4'd5; #1;
    check("alloc1_tag", 32'(alloc_tag), 32'd1);
    tick();
    alloc_dest = 4'd7; #1;
    check("alloc2_tag", 32'(alloc_tag), 32'd2);
    tick();
    alloc_valid = 1'b0; #1;
    check("alloc3_count", 32'(count), 32'd3);
    check("alloc3_commit", 32'(commit_valid), 32'd0);

    // CDB tag1 = 0x00AA; same-cycle lookup must not see it
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h00AA; rd_tag = 3'd1; #1;
    check("no_forward_rd_ready", 32'(rd_ready), 32'd0);
    tick();
    cdb_tag = 3'd0; cdb_data = 16'h0055; #1;
    check("cdb1_rd_ready", 32'(rd_ready), 32'd1);
    check("cdb1_rd_data", 32'(rd_data), 32'h00AA);
    check("cdb1_no_commit", 32'(commit_valid), 32'd0);
    tick();
    cdb_valid = 1'b0; #1;
    check("c0_valid", 32'(commit_valid), 32'd1);
    check("c0_tag", 32'(commit_tag), 32'd0);
    check("c0_dest", 32'(commit_dest), 32'd3);
    check("c0_data", 32'(commit_data), 32'h0055);
    tick();
    #1;
    check("c1_valid", 32'(commit_valid), 32'd1);
    check("c1_tag", 32'(commit_tag), 32'd1);
    check("c1_dest", 32'(commit_dest), 32'd5);
    check("c1_data", 32'(commit_data), 32'h00AA);
    check("c1_count", 32'(count), 32'd2);
    tick();
    #1;
    check("c2_no_commit", 32'(commit_valid), 32'd0);
    check("c2_count", 32'(count), 32'd1);

    // CDB to an invalid entry is ignored
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'hBEEF;
    tick();
    cdb_valid = 1'b0; rd_tag = 3'd5; #1;
    check("cdb_invalid_ignored", 32'(rd_ready), 32'd0);

    // Flush, then fill all 8 entries with dests 1..8
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_dest = 4'(i + 1);
      tick();
    end
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(alloc_ready), 32'd0);
    check("fill_count", 32'(count), 32'd8);
    alloc_dest = 4'd9;
    tick();
    alloc_valid = 1'b0; #1;
    check("ninth_ignored_count", 32'(count), 32'd8);
    check("ninth_ignored_tag", 32'(alloc_tag), 32'd0);

    // Ready the head, then commit against a refused allocation
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h1234;
    tick();
    cdb_valid = 1'b0; alloc_valid = 1'b1; alloc_dest = 4'd10; #1;
    check("full_commit_valid", 32'(commit_valid), 32'd1);
    check("full_commit_dest", 32'(commit_dest), 32'd1);
    check("full_alloc_refused", 32'(alloc_ready), 32'd0);
    tick();
    alloc_valid = 1'b0; #1;
    check("full_commit_count", 32'(count), 32'd7);
    check("wrap_ready", 32'(alloc_ready), 32'd1);
    check("wrap_tag", 32'(alloc_tag), 32'd0);
    alloc_valid = 1'b1; alloc_dest = 4'd11;
    tick();
    alloc_valid = 1'b0; rd_tag = 3'd0; #1;
    check("wrap_count", 32'(count), 32'd8);
    check("wrap_slot_not_ready", 32'(rd_ready), 32'd0);
    check("wrap_slot_data_zero", 32'(rd_data), 32'd0);

    // Flush with 5 entries, head ready, concurrent alloc and CDB
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_dest = 4'(i + 2);
      tick();
    end
    alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0077;
    tick();
    cdb_valid = 1'b0; #1;
    check("pre_flush_count", 32'(count), 32'd5);
    check("pre_flush_commit", 32'(commit_valid), 32'd1);
    flush = 1'b1; alloc_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd1; #1;
    check("flush_masks_commit", 32'(commit_valid), 32'd0);
    tick();
    flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0; rd_tag = 3'd0; #1;
    check("post_flush_count", 32'(count), 32'd0);
    check("post_flush_empty", 32'(empty), 32'd1);
    check("post_flush_tag", 32'(alloc_tag), 32'd0);
    check("post_flush_commit", 32'(commit_valid), 32'd0);
    check("post_flush_rd_ready", 32'(rd_ready), 32'd0);

    // Asynchronous reset mid-cycle with 4 entries in flight
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_dest = 4'(i + 4);
      tick();
    end
    alloc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0F0F;
    tick();
    cdb_valid = 1'b0; #1;
    check("pre_rst_count", 32'(count), 32'd4);
    rst_n = 1'b0; #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_tag", 32'(alloc_tag), 32'd0);
    check("async_rst_commit", 32'(commit_valid), 32'd0);
    check("async_rst_ready", 32'(alloc_ready), 32'd1);
    check("async_rst_empty", 32'(empty), 32'd1);
    tick();
    rst_n = 1'b1;
    alloc_valid = 1'b1; alloc_dest = 4'd12; #1;
    check("post_rst_tag", 32'(alloc_tag), 32'd0);
    tick();
    alloc_valid = 1'b0; #1;
    check("post_rst_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
